sseg_mux_pwm: RTL
=================

// Module: sseg_mux_pwm
// PURPOSE
//  Parametrised N-digit multiplexed seven-segment driver with hex decode.
//  Adds per-digit decimal point and blanking, and PWM brightness control.
//  Double-buffers display data so updates land only at frame boundaries.
//  Sits between the control logic and the board's common-anode LED display pins.
// PARAMETERS
//  NDIG   4   digit count, 2..8; power of two not required
//  DIV_W  17  prescaler width; one digit slot = 2^DIV_W clocks
//  BRI_W  4   brightness width; BRI_W <= DIV_W
// PORTS
//  clock     in   1        system clock, rising edge
//  reset     in   1        asynchronous, active-high
//  load      in   1        capture digits/dp_in/blank_in into shadow buffer
//  digits    in   4*NDIG   hex nibble per digit; digit0 = [3:0], the rightmost digit
//  dp_in     in   NDIG     1 = decimal point lit for that digit
//  blank_in  in   NDIG     1 = digit fully dark
//  bright    in   BRI_W    duty: 0 = dark, 2^BRI_W-1 = brightest
//  a..g, dp  out  1 each   segment cathodes, active-low
//  an        out  NDIG     digit anodes, active-low, at most one low
//  frame_tick out 1        1-clock pulse when the display index wraps to 0
// BEHAVIOUR
//  Reset (async): prescaler pre=0, idx=0.
//   Shadow and active digits/dp = 0; shadow and active blank = all 1.
//   Outputs: a..g = 1, dp = 1, an = all 1, frame_tick = 0.
//   Reset mid-operation darkens the display immediately, with no completion of the current slot.
//  Prescaler: pre increments every clock and wraps at 2^DIV_W-1 -> 0.
//   At pre == all-ones, idx advances. Wrap is NDIG-1 -> 0, explicit, with idx width clog2(NDIG), minimum 1.
//  Buffering:
//   load=1 -> shadow <= inputs on that edge.
//   On the idx wrap edge, active <= shadow.
//   If load coincides with the wrap, active <= inputs directly, and shadow is updated too.
//   A load mid-frame never alters the current frame.
//  PWM: pwm_cnt = pre[DIV_W-1 -: BRI_W]. The digit is lit while pwm_cnt < bright.
//   bright is sampled live, with no buffering.
//   bright=0 -> an all 1.
//  Decode: {g,f,e,d,c,b,a}, active-low.
//   0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011
//   C=1000110 d=0100001 E=0000110 F=0001110
//  Blanked digit, or PWM off phase: a..g = 1, dp = 1, an = all 1.
//   Otherwise an[idx] = 0 and dp = ~active_dp[idx].
//  Latency: every output is registered, 1 clock after the pre/idx state that selects it.
//   frame_tick is high in the cycle the registered outputs first show digit0 of the new frame.
// CONFIGURATION
//  SSEG_LZB_EN defined: leading-zero blanking on the active buffer.
//   Affects digit k > 0 with value 0 and dp clear, where every digit above k is also 0 with dp clear.
//   Such a digit is treated as blanked.
//   digit0 is never auto-blanked.
//  SSEG_LZB_EN undefined: zeros are always displayed, and only blank_in blanks.
// TESTING (bench: NDIG=4, DIV_W=4, BRI_W=2)
//  1. reset, then load digits=16'h1234, dp=0, blank=0, bright=3; wait for frame_tick
//     -> slot0: an=1110, segs=0011001 for 12 clocks, then an=1111 for 4; slots 1..3 show 3, 2, 1.
//  2. bright=0 for a whole frame -> an=1111 on every clock; frame_tick still pulses every 64 clocks.
//  3. load 16'hABCD mid-frame -> remaining slots still show 1234;
//     after frame_tick the digits show d, C, b, A.
//  4. blank_in=4'b1000, dp_in=4'b0001 -> an[3] never low; dp=0 only while an=1110 is lit.
//  5. reset asserted mid-slot -> same cycle: an=1111, segs=1111111, dp=1, frame_tick=0;
//     after release, first lit anode is an[0].
//  6. digits=16'h0050, dp=0, bright=3:
//     with SSEG_LZB_EN -> an[3] and an[2] never low, digit1 shows 5, digit0 shows 0;
//     without it -> all four digits lit, showing 0050.

Source files
------------

// File: rtl/sseg_mux_pwm.sv
// Multiplexed common-anode seven-segment driver: hex decode, per-digit dp/blank,
// frame-synchronous double buffering and PWM brightness. Optional: `define SSEG_LZB_EN.
module sseg_mux_pwm #(
  parameter int NDIG  = 4,
  parameter int DIV_W = 17,
  parameter int BRI_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp_in,
  input  logic [NDIG-1:0]   blank_in,
  input  logic [BRI_W-1:0]  bright,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              e,
  output logic              f,
  output logic              g,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              frame_tick
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  logic [DIV_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wrap_q, wrap_d;
  logic [4*NDIG-1:0] sh_dig_q, sh_dig_d, ac_dig_q, ac_dig_d;
  logic [NDIG-1:0]   sh_dp_q, sh_dp_d, ac_dp_q, ac_dp_d;
  logic [NDIG-1:0]   sh_bl_q, sh_bl_d, ac_bl_q, ac_bl_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              ft_q, ft_d;

  logic              slot_end_s;
  logic              frame_end_s;
  logic [BRI_W-1:0]  pwm_cnt_s;
  logic [NDIG-1:0]   dark_s;
  logic [3:0]        cur_dig_s;
  logic              lit_s;
`ifdef SSEG_LZB_EN
  logic              zero_run_s;
`endif

  // Segment pattern {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Scan timing and buffer transfer; a load on the wrap edge goes straight to active
  always_comb begin
    slot_end_s  = (pre_q == {DIV_W{1'b1}});
    frame_end_s = slot_end_s && (idx_q == IDX_LAST);
    pre_d       = pre_q + DIV_W'(1);
    wrap_d      = frame_end_s;
    if (frame_end_s) begin
      idx_d = '0;
    end else if (slot_end_s) begin
      idx_d = idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
    if (load) begin
      sh_dig_d = digits;
      sh_dp_d  = dp_in;
      sh_bl_d  = blank_in;
    end else begin
      sh_dig_d = sh_dig_q;
      sh_dp_d  = sh_dp_q;
      sh_bl_d  = sh_bl_q;
    end
    if (frame_end_s) begin
      ac_dig_d = sh_dig_d;
      ac_dp_d  = sh_dp_d;
      ac_bl_d  = sh_bl_d;
    end else begin
      ac_dig_d = ac_dig_q;
      ac_dp_d  = ac_dp_q;
      ac_bl_d  = ac_bl_q;
    end
  end

  // Per-digit dark mask: explicit blanking, plus leading zeros when enabled
  always_comb begin
    dark_s = ac_bl_q;
`ifdef SSEG_LZB_EN
    zero_run_s = 1'b1;
    for (int k = NDIG - 1; k > 0; k--) begin
      zero_run_s = zero_run_s & (ac_dig_q[4*k +: 4] == 4'h0) & ~ac_dp_q[k];
      dark_s[k]  = dark_s[k] | zero_run_s;
    end
`endif
  end

  // Output selection for the current slot and PWM phase
  always_comb begin
    pwm_cnt_s = pre_q[DIV_W-1 -: BRI_W];
    cur_dig_s = ac_dig_q[4*idx_q +: 4];
    lit_s     = (pwm_cnt_s < bright) && !dark_s[idx_q];
    ft_d      = wrap_q;
    if (lit_s) begin
      seg_d = seg_decode(cur_dig_s);
      dp_d  = ~ac_dp_q[idx_q];
      an_d  = ~(NDIG'(1) << idx_q);
    end else begin
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      an_d  = '1;
    end
  end

  // Scan state and display buffers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q    <= '0;
      idx_q    <= '0;
      wrap_q   <= 1'b0;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_bl_q  <= '1;
      ac_dig_q <= '0;
      ac_dp_q  <= '0;
      ac_bl_q  <= '1;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      wrap_q   <= wrap_d;
      sh_dig_q <= sh_dig_d;
      sh_dp_q  <= sh_dp_d;
      sh_bl_q  <= sh_bl_d;
      ac_dig_q <= ac_dig_d;
      ac_dp_q  <= ac_dp_d;
      ac_bl_q  <= ac_bl_d;
    end
  end

  // Output registers; reset darkens the display at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      an_q  <= '1;
      ft_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      ft_q  <= ft_d;
    end
  end

  assign {g, f, e, d, c, b, a} = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = ft_q;

endmodule
